// File: rtl/fifo_stream_reader_if.sv
// ============================================================================
//  Module      : fifo_stream_reader_if
//  Description : FIFO read-port and valid/ready stream bundle for the reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface fifo_stream_reader_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_ren;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    // master: the reader itself; slave: the FIFO plus downstream consumer
    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_ren, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_ren, m_valid, m_data
    );
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Pops a 1-cycle-latency FIFO into a 2-entry buffer feeding a
//                valid/ready stream at full rate without over-reading.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_stream_reader #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_stream_reader_if.master bus,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     pop_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_head;
    logic [DW-1:0]   r_tail;
    logic [DW-1:0]   w_head_nxt;
    logic [DW-1:0]   w_tail_nxt;
    logic            r_inflight;
    logic [CNT_W-1:0] r_pop_count;

    logic            w_transfer;
    logic            w_capture;
    logic            w_ren;
    logic [2:0]      w_credit;

    assign occupancy   = r_state;
    assign pop_count   = r_pop_count;
    assign bus.m_valid = (r_state != S_EMPTY);
    assign bus.m_data  = r_head;
    assign bus.fifo_ren = w_ren;

    assign w_transfer = bus.m_valid && bus.m_ready;
    assign w_capture  = r_inflight;

    // Slots committed after this edge: buffered + arriving - leaving. A read is
    // only issued if its word is guaranteed a slot when it lands.
    assign w_credit = {1'b0, occupancy} + {2'b00, r_inflight} - {2'b00, w_transfer};
    assign w_ren    = !rst && en && !bus.fifo_empty && (w_credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_inflight  <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_inflight  <= w_ren;
            r_pop_count <= r_pop_count + {{(CNT_W-1){1'b0}}, w_transfer};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            S_EMPTY: begin
                if (w_capture) begin
                    w_head_nxt  = bus.fifo_dout;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_capture && !w_transfer) begin
                    w_tail_nxt  = bus.fifo_dout;
                    w_state_nxt = S_TWO;
                end else if (w_capture && w_transfer) begin
                    w_head_nxt  = bus.fifo_dout;
                end else if (w_transfer) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                // Capture here is unreachable by the credit rule; handled so
                // the buffer would still keep order rather than drop a word.
                if (w_transfer) begin
                    w_head_nxt = r_tail;
                    if (w_capture) begin
                        w_tail_nxt = bus.fifo_dout;
                    end else begin
                        w_state_nxt = S_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed bench with a behavioural FIFO and in-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        m_ready;
    logic        push;
    logic [7:0]  push_data;
    logic        hold_full;
    logic [1:0]  occ;
    logic [1:0]  occ4;
    logic [15:0] pcnt;
    logic [3:0]  pcnt4;

    fifo_stream_reader_if #(.DW(DW)) bus ();
    fifo_stream_reader_if #(.DW(DW)) bus4 ();

    fifo_stream_reader #(.DW(DW), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .occupancy (occ),
        .pop_count (pcnt)
    );

    // Second copy sees identical inputs, so it tracks dut cycle for cycle;
    // only its narrow pop counter is observed.
    fifo_stream_reader #(.DW(DW), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus4),
        .occupancy (occ4),
        .pop_count (pcnt4)
    );

    // Behavioural 16-deep FIFO with registered read data
    logic [7:0] fmem [16];
    logic [4:0] fcnt;
    logic [3:0] wp;
    logic [3:0] rp;
    logic [7:0] fdout;
    logic       fpop;

    assign fpop = bus.fifo_ren && (fcnt != 5'd0);

    always @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            wp    <= '0;
            rp    <= '0;
            fdout <= '0;
        end else begin
            if (fpop) begin
                fdout <= fmem[rp];
                rp    <= rp + 4'd1;
            end
            if (push) begin
                fmem[wp] <= push_data;
                wp       <= wp + 4'd1;
            end
            fcnt <= fcnt + {4'b0, push} - {4'b0, fpop};
        end
    end

    assign bus.fifo_empty  = (fcnt == 5'd0) && !hold_full;
    assign bus.fifo_dout   = fdout;
    assign bus.m_ready     = m_ready;
    assign bus4.fifo_empty = bus.fifo_empty;
    assign bus4.fifo_dout  = bus.fifo_dout;
    assign bus4.m_ready    = m_ready;

    int         n_checks = 0;
    int         n_errors = 0;
    int         delivered = 0;
    bit         mon_on = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            push      = 1'b1;
            push_data = first + 8'(i);
            exp_q.push_back(first + 8'(i));
            tick();
        end
        push = 1'b0;
    endtask

    // Per-cycle protocol monitor and in-order scoreboard
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            check("ren_while_empty", 32'(bus.fifo_ren & bus.fifo_empty), 32'd0);
            check("occ_max", 32'(occ == 2'd3), 32'd0);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0)
                    check("extra_word", 32'(exp_q.size()), 32'd1);
                else
                    check("order", 32'(bus.m_data), 32'(exp_q.pop_front()));
                delivered++;
            end
        end
    end

    initial begin
        int nren;
        int base;

        rst = 1'b1; hold_full = 1'b1; en = 1'b1; m_ready = 1'b0;
        push = 1'b0; push_data = '0;

        // Reset with a non-empty FIFO must not read
        @(negedge clk);
        check("rst_ren_c0", 32'(bus.fifo_ren), 32'd0);
        tick();
        @(negedge clk);
        check("rst_ren_c1", 32'(bus.fifo_ren), 32'd0);
        check("rst_valid", 32'(bus.m_valid), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_pop", 32'(pcnt), 32'd0);
        check("rst_data", 32'(bus.m_data), 32'd0);
        tick();
        rst = 1'b0; hold_full = 1'b0; en = 1'b0; mon_on = 1'b1;

        // Streaming: 16 words back-to-back, 2-cycle latency from first read
        m_ready = 1'b1;
        push_words(8'h01, 16);
        en = 1'b1;
        @(negedge clk);
        check("stream_first_ren", 32'(bus.fifo_ren), 32'd1);
        check("stream_lat0", 32'(bus.m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("stream_lat1", 32'(bus.m_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(bus.m_valid), 32'd1);
            check("stream_data", 32'(bus.m_data), 32'(i + 1));
        end
        tick();
        @(negedge clk);
        check("stream_drained", 32'(bus.m_valid), 32'd0);
        check("stream_popcnt", 32'(pcnt), 32'd16);
        tick();

        // Backpressure: only two reads while stalled, head held stable
        en = 1'b0; m_ready = 1'b0;
        push_words(8'h21, 8);
        en = 1'b1;
        nren = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.fifo_ren) nren++;
            if (bus.m_valid) check("bp_hold", 32'(bus.m_data), 32'h21);
            tick();
        end
        @(negedge clk);
        check("bp_reads", 32'(nren), 32'd2);
        check("bp_occ", 32'(occ), 32'd2);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_data", 32'(bus.m_data), 32'h21);
        tick();
        base = delivered;
        m_ready = 1'b1;
        repeat (14) tick();
        check("bp_delivered", 32'(delivered - base), 32'd8);
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // Alternating ready
        en = 1'b0; m_ready = 1'b0;
        push_words(8'h41, 16);
        base = delivered;
        en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        check("alt_delivered", 32'(delivered - base), 32'd16);
        check("alt_left", 32'(exp_q.size()), 32'd0);

        // en dropped after the fifth read, then resumed
        en = 1'b0;
        push_words(8'h61, 10);
        base = delivered;
        en = 1'b1;
        nren = 0;
        for (int c = 0; c < 20 && nren < 5; c++) begin
            @(negedge clk);
            if (bus.fifo_ren) nren++;
            tick();
        end
        en = 1'b0;
        check("mid_reads", 32'(nren), 32'd5);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("mid_paused_ren", 32'(bus.fifo_ren), 32'd0);
            tick();
        end
        check("mid_delivered", 32'(delivered - base), 32'd5);
        en = 1'b1;
        repeat (15) tick();
        check("mid_total", 32'(delivered - base), 32'd10);
        check("mid_left", 32'(exp_q.size()), 32'd0);

        // Counter wrap on the 4-bit instance: 17 words -> 1
        en = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        push_words(8'h81, 16);
        en = 1'b1;
        tick();
        tick();
        push_words(8'h91, 1);
        repeat (25) tick();
        @(negedge clk);
        check("wrap_pop4", 32'(pcnt4), 32'd1);
        check("wrap_pop16", 32'(pcnt), 32'd17);
        tick();

        // Reset while the buffer is full discards everything
        en = 1'b0; m_ready = 1'b0;
        push_words(8'hA1, 4);
        en = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("pre_rst_occ", 32'(occ), 32'd2);
        check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(bus.m_valid), 32'd0);
        check("post_rst_occ", 32'(occ), 32'd0);
        check("post_rst_data", 32'(bus.m_data), 32'd0);
        check("post_rst_pop", 32'(pcnt), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
